dec_value_row: RTL and testbench

//  Text-row source for textEngine. Converts an unsigned binary value (e.g. counterM output)
//  to decimal using a sequential shift-add-3 (double-dabble) engine, holds the result in a

---
 rtl/dec_value_row_pkg.sv | 26 ++
 rtl/dec_value_row_if.sv | 13 +
 rtl/dec_value_row_bcd_shift_step.sv | 25 ++
 rtl/dec_value_row.sv | 112 +++++++++++
 tb/tb_dec_value_row.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/dec_value_row_pkg.sv
// Shared constants, FSM encoding and header lookup for the decimal text row.
// Imported by the interface-facing top and its datapath helpers.
package dec_value_row_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam int         ROW_COLS    = 16;
    localparam int         HDR_COLS    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } conv_state_e;

    // Fixed "DEC " label in the first four columns.
    function automatic logic [7:0] header_char(input logic [1:0] col);
        case (col)
            2'd0:    return 8'h44;
            2'd1:    return 8'h45;
            2'd2:    return 8'h43;
            default: return ASCII_SPACE;
        endcase
    endfunction

endpackage

// File: rtl/dec_value_row_if.sv
// Bus between textEngine/top and the decimal row: value in, column request in,
// registered character and conversion-busy flag out.
interface dec_value_row_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] value;
    logic [3:0]       charAddress;
    logic [7:0]       charOutput;
    logic             busy;

    modport master (output value, charAddress, input charOutput, busy);
    modport slave  (input value, charAddress, output charOutput, busy);
endinterface

// File: rtl/dec_value_row_bcd_shift_step.sv
// One combinational double-dabble step: add 3 to every nibble >= 5, then
// shift the BCD vector left by one, pulling in the next binary bit.
module dec_value_row_bcd_shift_step #(
    parameter int DIGITS = 5
) (
    input  logic [4*DIGITS-1:0] bcd_i,
    input  logic                bit_i,
    output logic [4*DIGITS-1:0] bcd_o
);

    logic [4*DIGITS-1:0] adj;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        adj = bcd_i;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_i[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
            end
        end
        // Any carry out of the top digit is dropped; DIGITS is sized so none occurs.
        bcd_o = {adj[4*DIGITS-2:0], bit_i};
    end

endmodule

// File: rtl/dec_value_row.sv
// Decimal text row: sequential binary-to-BCD conversion into a display register,
// plus a registered column decode producing "DEC " followed by the digits.
module dec_value_row
    import dec_value_row_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int DIGITS        = 5,
    parameter int LEADING_BLANK = 1
) (
    input  logic           clk,
    input  logic           reset,
    dec_value_row_if.slave bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    conv_state_e        state_q;
    logic [WIDTH-1:0]   shift_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_d;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [WIDTH-1:0]   latched_q;
    logic [WIDTH-1:0]   last_q;
    logic [BCD_W-1:0]   display_q;
    logic               busy_q;
    logic [7:0]         char_q;
    logic [7:0]         char_d;
    logic [DIGITS-1:0]  blank;

    dec_value_row_bcd_shift_step #(.DIGITS(DIGITS)) u_step (
        .bcd_i (bcd_q),
        .bit_i (shift_q[WIDTH-1]),
        .bcd_o (bcd_d)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            latched_q <= '0;
            last_q    <= '0;
            // NOTE: display_q is an ordinary register, not a RAM, so it is reset with the rest.
            display_q <= '0;
            busy_q    <= 1'b0;
            char_q    <= ASCII_SPACE;
        end else begin
            char_q <= char_d;
            case (state_q)
                ST_IDLE: begin
                    if (bus.value != last_q) begin
                        shift_q   <= bus.value;
                        bcd_q     <= '0;
                        bit_cnt_q <= CNT_W'(WIDTH);
                        latched_q <= bus.value;
                        busy_q    <= 1'b1;
                        state_q   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    shift_q   <= shift_q << 1;
                    bcd_q     <= bcd_d;
                    bit_cnt_q <= bit_cnt_q - 1'b1;
                    if (bit_cnt_q == CNT_W'(1)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    display_q <= bcd_q;
                    last_q    <= latched_q;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A digit blanks only while it and everything above it are zero; the LSD never blanks.
    always_comb begin
        logic lead;
        blank = '0;
        lead  = (LEADING_BLANK != 0);
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead     = lead && (display_q[4*i +: 4] == 4'd0);
            blank[i] = lead;
        end
    end

    always_comb begin
        int col;
        int dig;
        char_d = ASCII_SPACE;
        col    = int'(bus.charAddress);
        dig    = 0;
        if (col < HDR_COLS) begin
            char_d = header_char(bus.charAddress[1:0]);
        end else if (col < HDR_COLS + DIGITS) begin
            dig = DIGITS - 1 - (col - HDR_COLS);
            if (!blank[dig]) begin
                char_d = ASCII_ZERO + {4'd0, display_q[4*dig +: 4]};
            end
        end
    end

    assign bus.charOutput = char_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_dec_value_row.sv
// Directed bench for dec_value_row: one leading-blank instance and one zero-padded
// instance, expected characters queued at stimulus time and popped on output.
module tb_dec_value_row;
    import dec_value_row_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dec_value_row_if #(.WIDTH(16)) bus_b ();
    dec_value_row_if #(.WIDTH(16)) bus_z ();

    dec_value_row #(.WIDTH(16), .DIGITS(5), .LEADING_BLANK(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    dec_value_row #(.WIDTH(16), .DIGITS(5), .LEADING_BLANK(0)) dut_z (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_z)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] c);
        exp_q.push_back(c);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check({tag, " (scoreboard empty)"}, {24'd0, obs}, 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check(tag, {24'd0, obs}, {24'd0, e});
        end
    endtask

    task automatic read_row(input bit z, input string row);
        for (int c = 0; c < 16; c++) begin
            if (z) bus_z.charAddress = 4'(c);
            else   bus_b.charAddress = 4'(c);
            push(row[c]);
            tick();
            pop_chk($sformatf("%s col%0d", z ? "rowZ" : "rowB", c),
                    z ? bus_z.charOutput : bus_b.charOutput);
            check($sformatf("%s busy idle col%0d", z ? "rowZ" : "rowB", c),
                  {31'd0, z ? bus_z.busy : bus_b.busy}, 32'd0);
        end
    endtask

    // Value change, then busy for 17 cycles; display lands on edge 18, char on edge 19.
    task automatic conv_watch(input logic [15:0] v, input logic [3:0] col,
                              input logic [7:0] old_c, input logic [7:0] new_c,
                              input string tag);
        bus_b.charAddress = col;
        bus_b.value       = v;
        for (int k = 1; k <= 19; k++) begin
            if (k == 18) push(old_c);
            if (k == 19) push(new_c);
            tick();
            check($sformatf("%s busy k=%0d", tag, k), {31'd0, bus_b.busy},
                  (k <= 17) ? 32'd1 : 32'd0);
            if (k >= 18) pop_chk($sformatf("%s char k=%0d", tag, k), bus_b.charOutput);
        end
    endtask

    initial begin
        reset             = 1'b1;
        bus_b.value       = 16'd0;
        bus_b.charAddress = 4'd0;
        bus_z.value       = 16'd42;
        bus_z.charAddress = 4'd0;
        tick();
        tick();
        check("reset charB", {24'd0, bus_b.charOutput}, {24'd0, ASCII_SPACE});
        check("reset busyB", {31'd0, bus_b.busy}, 32'd0);
        check("reset charZ", {24'd0, bus_z.charOutput}, {24'd0, ASCII_SPACE});
        check("reset busyZ", {31'd0, bus_z.busy}, 32'd0);
        reset = 1'b0;

        // Value 0 after reset: no conversion, row shows a lone 0.
        read_row(1'b0, "DEC     0       ");

        conv_watch(16'd12345, 4'd4, " ", "1", "12345");
        read_row(1'b0, "DEC 12345       ");

        // Zero-padded instance converted 42 right after reset.
        read_row(1'b1, "DEC 00042       ");

        conv_watch(16'd65535, 4'd4, "1", "6", "65535");
        read_row(1'b0, "DEC 65535       ");
        conv_watch(16'd10, 4'd7, "3", "1", "10");
        read_row(1'b0, "DEC    10       ");

        // 100 then 200 mid-conversion: 100 shows first, 200 follows 18 cycles later.
        bus_b.charAddress = 4'd6;
        bus_b.value       = 16'd100;
        for (int k = 1; k <= 37; k++) begin
            if (k == 18) push(" ");
            if (k == 19) push("1");
            if (k == 36) push("1");
            if (k == 37) push("2");
            tick();
            check($sformatf("re-conv busy k=%0d", k), {31'd0, bus_b.busy},
                  ((k <= 17) || (k >= 19 && k <= 35)) ? 32'd1 : 32'd0);
            if (k == 18 || k == 19 || k == 36 || k == 37)
                pop_chk($sformatf("re-conv char k=%0d", k), bus_b.charOutput);
            if (k == 5) bus_b.value = 16'd200;
        end
        read_row(1'b0, "DEC   200       ");

        // Reset in the middle of converting 999.
        bus_b.charAddress = 4'd6;
        bus_b.value       = 16'd999;
        for (int k = 1; k <= 5; k++) tick();
        check("mid-conv busy", {31'd0, bus_b.busy}, 32'd1);
        reset = 1'b1;
        tick();
        check("abort busy", {31'd0, bus_b.busy}, 32'd0);
        check("abort char", {24'd0, bus_b.charOutput}, {24'd0, ASCII_SPACE});
        reset = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            if (k == 1)  push(" ");
            if (k == 18) push(" ");
            if (k == 19) push("9");
            tick();
            check($sformatf("999 busy k=%0d", k), {31'd0, bus_b.busy},
                  (k <= 17) ? 32'd1 : 32'd0);
            if (k == 1 || k == 18 || k == 19)
                pop_chk($sformatf("999 char k=%0d", k), bus_b.charOutput);
        end
        read_row(1'b0, "DEC   999       ");
        read_row(1'b1, "DEC 00042       ");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
